hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter WAIT_LIMIT, default 255, max consecutive memory-wait cycles before error.
REQ-002 CLK  in  1  single clock; all state updates on falling edge, same edge as pipeline registers.
REQ-003 Resetn  in  1  synchronous, active-low reset.
REQ-004 Rs_D, Rt_D  in  5 each  source registers of instruction in decode.
REQ-005 Rs_E, Rt_E, Rd_E  in  5 each  source/destination registers in execute.
REQ-006 RegWr_E, MemtoReg_E  in  1 each  execute-stage write-enable and load flag.
REQ-007 Rd_M, RegWr_M  in  5/1  memory-stage destination and write-enable.
REQ-008 Rd_WB, RegWr_WB  in  5/1  writeback-stage destination and write-enable.
REQ-009 Branch_E  in  1  branch taken, resolved in execute.
REQ-010 Jump_D  in  1  jump decoded in decode.
REQ-011 MemReq_M, MemRdy  in  1 each  data-memory access pending in M; memory completion.
REQ-012 Stall_F, Stall_D, Stall_E, Stall_M  out  1 each  hold the corresponding pipeline register.
REQ-013 Flush_D, Flush_E, Bubble_WB  out  1 each  load a bubble (all-zero) into the D, E, or M/WB register.
REQ-014 ForwardA_E, ForwardB_E  out  2 each  operand select: 00 regfile, 01 WB, 10 M.
REQ-015 State  out  2  FSM state; MemErr  out  1  sticky timeout flag; StallCycles  out  32  stall counter.

Function
REQ-016 FSM states SHALL be RUN=00, MEM_WAIT=01, ERR=10; 11 is unreachable and SHALL return to RUN.
REQ-017 RUN->MEM_WAIT when MemReq_M=1 and MemRdy=0; MEM_WAIT->RUN on MemRdy=1; MEM_WAIT->ERR when the wait counter reaches WAIT_LIMIT with MemRdy=0.
REQ-018 ERR SHALL hold until reset; in ERR, all Stall_* =1, Bubble_WB=1, MemErr=1.
REQ-019 The MEM_WAIT entry condition SHALL also apply combinationally in the detection cycle: Stall_F/D/E/M=1, Bubble_WB=1, all flushes 0.
REQ-020 While waiting, the wait counter (8 bits min.) SHALL increment each cycle and clear on entering RUN.
REQ-021 Load-use in RUN: MemtoReg_E & RegWr_E & Rd_E!=0 & (Rd_E==Rs_D | Rd_E==Rt_D) -> Stall_F=Stall_D=1, Flush_E=1 for exactly that cycle.
REQ-022 Branch_E in RUN -> Flush_D=Flush_E=1 and no stall; it overrides load-use.
REQ-023 Jump_D in RUN, with no branch or load-use -> Flush_D=1.
REQ-024 Priority: ERR > memory wait > branch > load-use > jump.
REQ-025 A branch seen during memory wait SHALL NOT flush; the held E register re-presents it, and it takes effect in the first RUN cycle.
REQ-026 ForwardA_E=10 if RegWr_M & Rd_M!=0 & Rd_M==Rs_E; else 01 if RegWr_WB & Rd_WB!=0 & Rd_WB==Rs_E; else 00. ForwardB_E follows the same rule on Rt_E.
REQ-027 Forwarding SHALL be combinational, zero latency, and independent of FSM state.
REQ-028 StallCycles SHALL increment on every edge where Stall_F=1, saturating at 32'hFFFFFFFF.

Reset
REQ-029 When Resetn=0 at a falling edge: State=RUN, wait counter=0, MemErr=0, StallCycles=0.
REQ-030 During reset, all Stall_*/Flush_*/Bubble_WB outputs SHALL be 0; reset SHALL abort MEM_WAIT or ERR immediately.

Structure
REQ-031 State encodings, forward-select codes, and the WAIT_LIMIT default SHALL live in shared package pipe_ctrl_pkg.
REQ-032 Forwarding logic SHALL be a sub-module forward_unit, instantiated once per operand.

Verification
REQ-033 Rd_M=5, RegWr_M=1, Rs_E=5, Rd_WB=5, RegWr_WB=1 -> ForwardA_E=10; with Rd_M=0 instead -> 01.
REQ-034 lw to Rd_E=8 in E, Rs_D=8 -> one cycle of Stall_F=Stall_D=Flush_E=1, then all 0; StallCycles +1.
REQ-035 MemReq_M=1, MemRdy low for 3 cycles -> State=01 for 3 cycles, stalls held, StallCycles +4, then RUN.
REQ-036 Branch_E=1 during MEM_WAIT -> no flush while waiting; Flush_D=Flush_E=1 in the first RUN cycle.
REQ-037 MemRdy held low for 256 cycles -> State=10, MemErr=1 persists; Resetn=0 one edge -> State=00, MemErr=0, StallCycles=0.
REQ-038 Branch_E=1 with a simultaneous load-use -> Flush_D=Flush_E=1, Stall_F=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control slice: FSM states, forwarding selects,
// the memory-wait timeout default and the bundle of hazard control outputs.
package pipe_ctrl_pkg;

    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_MEM_WAIT = 2'b01;
    localparam logic [1:0] ST_ERR      = 2'b10;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_WB = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int WAIT_LIMIT_DEFAULT = 255;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic bubble_wb;
    } hazard_ctl_t;

    // Freeze F..M and push a bubble into WB; used while memory is outstanding or dead.
    function automatic hazard_ctl_t hold_all();
        hazard_ctl_t c;
        c           = '0;
        c.stall_f   = 1'b1;
        c.stall_d   = 1'b1;
        c.stall_e   = 1'b1;
        c.stall_m   = 1'b1;
        c.bubble_wb = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Operand bypass select for one execute-stage source register.
// The M stage holds the youngest result, so it wins over WB; r0 never forwards.
module forward_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] rd_m,
    input  logic       regwr_m,
    input  logic [4:0] rd_wb,
    input  logic       regwr_wb,
    output logic [1:0] sel
);

    always_comb begin
        if (regwr_m && (rd_m != 5'd0) && (rd_m == src)) begin
            sel = FWD_M;
        end else if (regwr_wb && (rd_wb != 5'd0) && (rd_wb == src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard detection, stall/flush sequencing and operand forwarding for the 5-stage pipeline.
// Registers update on the falling edge, in step with the pipeline registers they steer.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
    input  logic        CLK,
    input  logic        Resetn,
    input  logic [4:0]  Rs_D,
    input  logic [4:0]  Rt_D,
    input  logic [4:0]  Rs_E,
    input  logic [4:0]  Rt_E,
    input  logic [4:0]  Rd_E,
    input  logic        RegWr_E,
    input  logic        MemtoReg_E,
    input  logic [4:0]  Rd_M,
    input  logic        RegWr_M,
    input  logic [4:0]  Rd_WB,
    input  logic        RegWr_WB,
    input  logic        Branch_E,
    input  logic        Jump_D,
    input  logic        MemReq_M,
    input  logic        MemRdy,
    output logic        Stall_F,
    output logic        Stall_D,
    output logic        Stall_E,
    output logic        Stall_M,
    output logic        Flush_D,
    output logic        Flush_E,
    output logic        Bubble_WB,
    output logic [1:0]  ForwardA_E,
    output logic [1:0]  ForwardB_E,
    output logic [1:0]  State,
    output logic        MemErr,
    output logic [31:0] StallCycles
);

    localparam int CW = ($clog2(WAIT_LIMIT + 1) > 8) ? $clog2(WAIT_LIMIT + 1) : 8;
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [CW-1:0] wait_cnt;
    logic          mem_detect;
    logic          load_use;
    hazard_ctl_t   ctl;

    assign mem_detect = MemReq_M && !MemRdy;
    assign load_use   = MemtoReg_E && RegWr_E && (Rd_E != 5'd0) &&
                        ((Rd_E == Rs_D) || (Rd_E == Rt_D));

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (mem_detect) state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (MemRdy) begin
                    state_d = ST_RUN;
                end else if (wait_cnt >= LIMIT) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_RUN;
        endcase
    end

    // A branch seen while frozen is not acted on: the held E register re-presents it later.
    always_comb begin
        ctl = '0;
        if (Resetn) begin
            case (state_q)
                ST_RUN: begin
                    if (mem_detect) begin
                        ctl = hold_all();
                    end else if (Branch_E) begin
                        ctl.flush_d = 1'b1;
                        ctl.flush_e = 1'b1;
                    end else if (load_use) begin
                        ctl.stall_f = 1'b1;
                        ctl.stall_d = 1'b1;
                        ctl.flush_e = 1'b1;
                    end else if (Jump_D) begin
                        ctl.flush_d = 1'b1;
                    end
                end
                ST_MEM_WAIT, ST_ERR: ctl = hold_all();
                default: ctl = '0;
            endcase
        end
    end

    assign Stall_F   = ctl.stall_f;
    assign Stall_D   = ctl.stall_d;
    assign Stall_E   = ctl.stall_e;
    assign Stall_M   = ctl.stall_m;
    assign Flush_D   = ctl.flush_d;
    assign Flush_E   = ctl.flush_e;
    assign Bubble_WB = ctl.bubble_wb;
    assign State     = state_q;

    forward_unit u_fwd_a (
        .src      (Rs_E),
        .rd_m     (Rd_M),
        .regwr_m  (RegWr_M),
        .rd_wb    (Rd_WB),
        .regwr_wb (RegWr_WB),
        .sel      (ForwardA_E)
    );

    forward_unit u_fwd_b (
        .src      (Rt_E),
        .rd_m     (Rd_M),
        .regwr_m  (RegWr_M),
        .rd_wb    (Rd_WB),
        .regwr_wb (RegWr_WB),
        .sel      (ForwardB_E)
    );

    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(negedge CLK) begin
        if (!Resetn) begin
            state_q     <= ST_RUN;
            wait_cnt    <= '0;
            MemErr      <= 1'b0;
            StallCycles <= '0;
        end else begin
            state_q <= state_d;
            // The detection cycle counts as the first wait cycle.
            if (state_d == ST_MEM_WAIT) begin
                wait_cnt <= wait_cnt + CW'(1);
            end else if (state_d == ST_RUN) begin
                wait_cnt <= '0;
            end
            if (state_d == ST_ERR) MemErr <= 1'b1;
            if (ctl.stall_f && (StallCycles != 32'hFFFF_FFFF)) begin
                StallCycles <= StallCycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a behavioural model checked every cycle,
// plus hand-computed literal expectations at the key points of each scenario.
module tb_hazard_ctrl;

    localparam int WAIT_LIMIT = 255;

    logic        CLK;
    logic        Resetn;
    logic [4:0]  Rs_D, Rt_D, Rs_E, Rt_E, Rd_E, Rd_M, Rd_WB;
    logic        RegWr_E, MemtoReg_E, RegWr_M, RegWr_WB;
    logic        Branch_E, Jump_D, MemReq_M, MemRdy;
    logic        Stall_F, Stall_D, Stall_E, Stall_M;
    logic        Flush_D, Flush_E, Bubble_WB;
    logic [1:0]  ForwardA_E, ForwardB_E, State;
    logic        MemErr;
    logic [31:0] StallCycles;

    hazard_ctrl #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .CLK(CLK), .Resetn(Resetn),
        .Rs_D(Rs_D), .Rt_D(Rt_D), .Rs_E(Rs_E), .Rt_E(Rt_E), .Rd_E(Rd_E),
        .RegWr_E(RegWr_E), .MemtoReg_E(MemtoReg_E),
        .Rd_M(Rd_M), .RegWr_M(RegWr_M), .Rd_WB(Rd_WB), .RegWr_WB(RegWr_WB),
        .Branch_E(Branch_E), .Jump_D(Jump_D), .MemReq_M(MemReq_M), .MemRdy(MemRdy),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
        .Flush_D(Flush_D), .Flush_E(Flush_E), .Bubble_WB(Bubble_WB),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .State(State), .MemErr(MemErr), .StallCycles(StallCycles)
    );

    initial begin
        CLK = 1'b1;
        forever #5 CLK = ~CLK;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Control vector order: {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Bubble_WB}
    localparam logic [6:0] V_HOLD   = 7'b1111001;
    localparam logic [6:0] V_BRANCH = 7'b0000110;
    localparam logic [6:0] V_LU     = 7'b1100010;
    localparam logic [6:0] V_JUMP   = 7'b0000100;

    logic        model_valid = 1'b0;
    logic        m_err, m_waiting;
    int          m_low;
    logic [31:0] m_stalls;
    logic        lu_m, hold_m;
    logic [6:0]  exp_vec;
    logic [1:0]  exp_state, exp_fa, exp_fb;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] rdm,
                                           input logic wm, input logic [4:0] rdwb, input logic wwb);
        if (wm && rdm != 5'd0 && rdm == src) return 2'b10;
        if (wwb && rdwb != 5'd0 && rdwb == src) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        lu_m   = MemtoReg_E && RegWr_E && (Rd_E != 5'd0) && (Rd_E == Rs_D || Rd_E == Rt_D);
        hold_m = m_err || m_waiting || (MemReq_M && !MemRdy);
        if (!Resetn)       exp_vec = 7'b0;
        else if (hold_m)   exp_vec = V_HOLD;
        else if (Branch_E) exp_vec = V_BRANCH;
        else if (lu_m)     exp_vec = V_LU;
        else if (Jump_D)   exp_vec = V_JUMP;
        else               exp_vec = 7'b0;
        exp_state = m_err ? 2'b10 : (m_waiting ? 2'b01 : 2'b00);
        exp_fa    = fwd_sel(Rs_E, Rd_M, RegWr_M, Rd_WB, RegWr_WB);
        exp_fb    = fwd_sel(Rt_E, Rd_M, RegWr_M, Rd_WB, RegWr_WB);
    end

    // m_low counts consecutive MemRdy-low cycles of the current wait; WAIT_LIMIT+1 of them is fatal.
    always @(negedge CLK) begin
        if (!Resetn) begin
            m_err       <= 1'b0;
            m_waiting   <= 1'b0;
            m_low       <= 0;
            m_stalls    <= 32'd0;
            model_valid <= 1'b1;
        end else if (model_valid) begin
            if (exp_vec[6] && m_stalls != 32'hFFFF_FFFF) m_stalls <= m_stalls + 32'd1;
            if (!m_err) begin
                if (m_waiting) begin
                    if (MemRdy) begin
                        m_waiting <= 1'b0;
                        m_low     <= 0;
                    end else if (m_low + 1 >= WAIT_LIMIT + 1) begin
                        m_err     <= 1'b1;
                        m_waiting <= 1'b0;
                    end else begin
                        m_low <= m_low + 1;
                    end
                end else if (MemReq_M && !MemRdy) begin
                    m_waiting <= 1'b1;
                    m_low     <= 1;
                end
            end
        end
    end

    always @(posedge CLK) begin
        if (model_valid) begin
            check("ctl_vec", 64'({Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Bubble_WB}),
                  64'(exp_vec));
            check("fwd_a", 64'(ForwardA_E), 64'(exp_fa));
            check("fwd_b", 64'(ForwardB_E), 64'(exp_fb));
            check("state", 64'(State), 64'(exp_state));
            check("mem_err", 64'(MemErr), 64'(m_err));
            check("stall_cycles", 64'(StallCycles), 64'(m_stalls));
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [6:0] dut_vec();
        return {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Bubble_WB};
    endfunction

    task automatic sample();
        @(posedge CLK);
        #1;
    endtask

    task automatic advance();
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        Rs_D = 0; Rt_D = 0; Rs_E = 0; Rt_E = 0; Rd_E = 0; Rd_M = 0; Rd_WB = 0;
        RegWr_E = 0; MemtoReg_E = 0; RegWr_M = 0; RegWr_WB = 0;
        Branch_E = 0; Jump_D = 0; MemReq_M = 0; MemRdy = 0;
    endtask

    // One memory wait: MemRdy low for low_cycles cycles, then high; branch optionally pending.
    task automatic mem_wait_seq(input int low_cycles, input logic branch, input logic [31:0] sc_after);
        MemReq_M = 1; Branch_E = branch;
        Rs_E = 5'd5; Rd_M = 5'd5; RegWr_M = 1;
        for (int i = 0; i <= low_cycles; i++) begin
            MemRdy = (i == low_cycles);
            sample();
            check("wait_vec", 64'(dut_vec()), 64'(V_HOLD));
            check("wait_state", 64'(State), (i == 0) ? 64'd0 : 64'd1);
            check("wait_fwd_a", 64'(ForwardA_E), 64'(2'b10));
            advance();
        end
        MemReq_M = 0; MemRdy = 0; RegWr_M = 0;
        sample();
        check("resume_state", 64'(State), 64'd0);
        check("resume_vec", 64'(dut_vec()), branch ? 64'(V_BRANCH) : 64'd0);
        check("resume_sc", 64'(StallCycles), 64'(sc_after));
        advance();
        Branch_E = 0;
    endtask

    typedef struct {
        logic [4:0] rs, rt, rd_m;
        logic       wm;
        logic [4:0] rd_wb;
        logic       wwb;
        logic [1:0] ea, eb;
    } fwd_vec_t;

    fwd_vec_t fv [7] = '{
        '{5'd5,  5'd5, 5'd5,  1'b1, 5'd5, 1'b1, 2'b10, 2'b10},
        '{5'd5,  5'd5, 5'd0,  1'b1, 5'd5, 1'b1, 2'b01, 2'b01},
        '{5'd5,  5'd7, 5'd7,  1'b1, 5'd5, 1'b1, 2'b01, 2'b10},
        '{5'd5,  5'd7, 5'd5,  1'b0, 5'd5, 1'b0, 2'b00, 2'b00},
        '{5'd0,  5'd0, 5'd0,  1'b1, 5'd0, 1'b1, 2'b00, 2'b00},
        '{5'd3,  5'd3, 5'd3,  1'b0, 5'd3, 1'b1, 2'b01, 2'b01},
        '{5'd31, 5'd1, 5'd31, 1'b1, 5'd1, 1'b1, 2'b10, 2'b01}
    };

    typedef struct {
        logic       mtr, rwe;
        logic [4:0] rd_e, rs_d, rt_d;
        logic       br, jp;
        logic [6:0] ev;
    } ctl_vec_t;

    ctl_vec_t cv [12] = '{
        '{1'b1, 1'b1, 5'd8, 5'd8, 5'd0,  1'b0, 1'b0, V_LU},
        '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 7'b0},
        '{1'b1, 1'b1, 5'd9, 5'd3, 5'd9,  1'b0, 1'b0, V_LU},
        '{1'b1, 1'b1, 5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 7'b0},
        '{1'b0, 1'b1, 5'd8, 5'd8, 5'd8,  1'b0, 1'b0, 7'b0},
        '{1'b1, 1'b0, 5'd8, 5'd8, 5'd8,  1'b0, 1'b0, 7'b0},
        '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0,  1'b1, 1'b0, V_BRANCH},
        '{1'b1, 1'b1, 5'd8, 5'd8, 5'd0,  1'b1, 1'b0, V_BRANCH},
        '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 1'b1, V_JUMP},
        '{1'b1, 1'b1, 5'd8, 5'd0, 5'd8,  1'b0, 1'b1, V_LU},
        '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0,  1'b1, 1'b1, V_BRANCH},
        '{1'b1, 1'b1, 5'd8, 5'd9, 5'd10, 1'b0, 1'b0, 7'b0}
    };

    initial begin
        clear_inputs();
        // Hazards asserted under reset must not reach the outputs.
        Resetn = 0; MemReq_M = 1; Branch_E = 1; Jump_D = 1;
        advance();
        sample();
        check("rst_vec", 64'(dut_vec()), 64'd0);
        check("rst_state", 64'(State), 64'd0);
        check("rst_mem_err", 64'(MemErr), 64'd0);
        check("rst_sc", 64'(StallCycles), 64'd0);
        advance();
        clear_inputs();
        Resetn = 1;

        foreach (fv[i]) begin
            Rs_E = fv[i].rs; Rt_E = fv[i].rt; Rd_M = fv[i].rd_m; RegWr_M = fv[i].wm;
            Rd_WB = fv[i].rd_wb; RegWr_WB = fv[i].wwb;
            sample();
            check($sformatf("fwd_a_%0d", i), 64'(ForwardA_E), 64'(fv[i].ea));
            check($sformatf("fwd_b_%0d", i), 64'(ForwardB_E), 64'(fv[i].eb));
            advance();
        end
        clear_inputs();

        foreach (cv[i]) begin
            MemtoReg_E = cv[i].mtr; RegWr_E = cv[i].rwe; Rd_E = cv[i].rd_e;
            Rs_D = cv[i].rs_d; Rt_D = cv[i].rt_d; Branch_E = cv[i].br; Jump_D = cv[i].jp;
            sample();
            check($sformatf("ctl_%0d", i), 64'(dut_vec()), 64'(cv[i].ev));
            if (i == 1) check("lu_count", 64'(StallCycles), 64'd1);
            advance();
        end
        clear_inputs();
        sample();
        check("table_sc", 64'(StallCycles), 64'd3);
        advance();

        mem_wait_seq(3, 1'b0, 32'd7);
        mem_wait_seq(3, 1'b1, 32'd11);
        mem_wait_seq(WAIT_LIMIT, 1'b0, 32'd267);

        MemReq_M = 1; MemRdy = 0;
        for (int i = 0; i <= WAIT_LIMIT; i++) begin
            sample();
            advance();
        end
        sample();
        check("err_state", 64'(State), 64'd2);
        check("err_flag", 64'(MemErr), 64'd1);
        check("err_vec", 64'(dut_vec()), 64'(V_HOLD));
        check("err_sc", 64'(StallCycles), 64'd523);
        MemReq_M = 0; MemRdy = 1;
        for (int k = 0; k < 3; k++) begin
            advance();
            sample();
            check("err_sticky", 64'(State), 64'd2);
        end
        advance();
        Resetn = 0;
        sample();
        check("rst2_vec", 64'(dut_vec()), 64'd0);
        check("rst2_sc_pre", 64'(StallCycles), 64'd527);
        advance();
        Resetn = 1; MemRdy = 0; Jump_D = 1;
        sample();
        check("rst2_state", 64'(State), 64'd0);
        check("rst2_mem_err", 64'(MemErr), 64'd0);
        check("rst2_sc", 64'(StallCycles), 64'd0);
        check("rst2_jump", 64'(dut_vec()), 64'(V_JUMP));
        advance();
        clear_inputs();
        sample();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
